// File: rtl/l1d_pkg.sv
// Shared types and derived-geometry helpers for the L1 data cache.
package l1d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL_REQ,
        FILL_WAIT,
        RESP,
        FLUSH
    } l1d_state_e;

    // Metadata tag is stored zero-extended so one struct serves every geometry.
    localparam int L1D_TAG_MAX = 32;

    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [L1D_TAG_MAX-1:0] tag;
    } l1d_meta_t;

    function automatic int l1d_sets(input int c, input int a, input int b);
        return c / (a * b);
    endfunction

    function automatic int l1d_off_bits(input int b);
        return $clog2(b);
    endfunction

    function automatic int l1d_idx_bits(input int c, input int a, input int b);
        return $clog2(l1d_sets(c, a, b));
    endfunction

    function automatic int l1d_tag_bits(input int paddr, input int c, input int a, input int b);
        return paddr - l1d_idx_bits(c, a, b) - l1d_off_bits(b);
    endfunction

endpackage

// File: rtl/l1d_victim_sel.sv
// Victim way selection: first invalid way wins, otherwise the set's round-robin pointer.
module l1d_victim_sel #(
    parameter int A     = 3,
    parameter int S     = 8,
    parameter int IDX_W = 3,
    parameter int WAY_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [A-1:0]     valid_mask,
    input  logic             advance,
    output logic [WAY_W-1:0] victim_way
);

    logic [WAY_W-1:0] ptr_q [S];

    always_comb begin
        victim_way = ptr_q[set_idx];
        for (int w = A - 1; w >= 0; w--) begin
            if (!valid_mask[w]) victim_way = WAY_W'(w);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < S; s++) ptr_q[s] <= '0;
        end else if (advance) begin
            ptr_q[set_idx] <= (ptr_q[set_idx] == WAY_W'(A - 1)) ? '0 : ptr_q[set_idx] + 1'b1;
        end
    end

endmodule

// File: rtl/l1d_cache.sv
// Blocking write-back, write-allocate set-associative L1 data cache with full flush.
// Optional hit/miss counters are built when L1D_STATS_EN is defined.
module l1d_cache
    import l1d_pkg::*;
#(
    parameter int A          = 3,
    parameter int B          = 64,
    parameter int C          = 1536,
    parameter int PADDR_BITS = 19,
    parameter int TAG_BITS   = 10
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,
    input  logic                  cs_N_in,
    input  logic                  flush_in,
    input  logic                  lsu_valid_in,
    input  logic                  lsu_ready_in,
    input  logic [63:0]           lsu_addr_in,
    input  logic [63:0]           lsu_value_in,
    input  logic [TAG_BITS-1:0]   lsu_tag_in,
    input  logic                  lsu_we_in,
    output logic                  lsu_valid_out,
    output logic                  lsu_ready_out,
    output logic [63:0]           lsu_addr_out,
    output logic [63:0]           lsu_value_out,
    output logic [TAG_BITS-1:0]   lsu_tag_out,
    output logic                  lsu_write_complete_out,
    output logic                  l2_valid_out,
    input  logic                  l2_ready_in,
    output logic [PADDR_BITS-1:0] l2_addr_out,
    output logic                  l2_we_out,
    output logic [8*B-1:0]        l2_value_out,
    input  logic                  l2_valid_in,
    input  logic [8*B-1:0]        l2_value_in,
    output l1d_state_e            state_dbg_out
`ifdef L1D_STATS_EN
    ,
    output logic [31:0]           hit_count_out,
    output logic [31:0]           miss_count_out
`endif
);

    localparam int S      = l1d_sets(C, A, B);
    localparam int OFF_W  = l1d_off_bits(B);
    localparam int IDX_W  = l1d_idx_bits(C, A, B);
    localparam int TAG_W  = l1d_tag_bits(PADDR_BITS, C, A, B);
    localparam int WAY_W  = (A > 1) ? $clog2(A) : 1;
    localparam int WSEL_W = OFF_W - 3;

    l1d_state_e            state_q;
    l1d_meta_t             meta_q [S][A];
    logic [8*B-1:0]        data_q [S][A];
    logic [63:0]           req_addr_q, req_value_q, resp_value_q;
    logic [TAG_BITS-1:0]   req_tag_q;
    logic                  req_we_q, flush_pend_q, lsu_valid_q, l2_valid_q, l2_we_q;
    logic [PADDR_BITS-1:0] l2_addr_q;
    logic [8*B-1:0]        l2_value_q;
    logic [WAY_W-1:0]      vic_way_q, fl_way_q;
    logic [IDX_W-1:0]      fl_set_q;

    logic [IDX_W-1:0]  in_idx, rq_idx;
    logic [TAG_W-1:0]  in_tag, rq_tag;
    logic [WSEL_W-1:0] in_word, rq_word;
    logic              accept, hit, fl_dirty, fl_last;
    logic [WAY_W-1:0]  hit_way, vic_way;
    logic [A-1:0]      valid_mask;
    logic [8*B-1:0]    hit_line, store_line, fill_line;

    assign in_idx  = lsu_addr_in[OFF_W +: IDX_W];
    assign in_tag  = lsu_addr_in[OFF_W+IDX_W +: TAG_W];
    assign in_word = lsu_addr_in[3 +: WSEL_W];
    assign rq_idx  = req_addr_q[OFF_W +: IDX_W];
    assign rq_tag  = req_addr_q[OFF_W+IDX_W +: TAG_W];
    assign rq_word = req_addr_q[3 +: WSEL_W];

    // Request handshake: a request transfers on a cycle where lsu_valid_in && lsu_ready_out;
    // a completion transfers on a cycle where lsu_valid_out && lsu_ready_in, and the L2
    // request on l2_valid_out && l2_ready_in. Valid-side outputs hold steady until transfer.
    assign lsu_ready_out = (state_q == IDLE) && !cs_N_in && !flush_in && !flush_pend_q;
    assign accept        = lsu_valid_in && lsu_ready_out;

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        valid_mask = '0;
        for (int w = 0; w < A; w++) begin
            valid_mask[w] = meta_q[in_idx][w].valid;
            if (meta_q[in_idx][w].valid && meta_q[in_idx][w].tag == L1D_TAG_MAX'(in_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        hit_line   = data_q[in_idx][hit_way];
        store_line = hit_line;
        store_line[in_word*64 +: 64] = lsu_value_in;
        fill_line  = l2_value_in;
        if (req_we_q) fill_line[rq_word*64 +: 64] = req_value_q;
    end

    assign fl_dirty = meta_q[fl_set_q][fl_way_q].valid && meta_q[fl_set_q][fl_way_q].dirty;
    assign fl_last  = (fl_set_q == IDX_W'(S - 1)) && (fl_way_q == WAY_W'(A - 1));

    l1d_victim_sel #(.A(A), .S(S), .IDX_W(IDX_W), .WAY_W(WAY_W)) u_victim_sel (
        .clk        (clk_in),
        .rst_n      (rst_N_in),
        .set_idx    (in_idx),
        .valid_mask (valid_mask),
        .advance    (accept && !hit),
        .victim_way (vic_way)
    );

    always_ff @(posedge clk_in) begin
        if (accept && hit && lsu_we_in) data_q[in_idx][hit_way] <= store_line;
        else if (state_q == FILL_WAIT && l2_valid_in) data_q[rq_idx][vic_way_q] <= fill_line;
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            req_value_q  <= '0;
            req_tag_q    <= '0;
            req_we_q     <= 1'b0;
            resp_value_q <= '0;
            flush_pend_q <= 1'b0;
            lsu_valid_q  <= 1'b0;
            l2_valid_q   <= 1'b0;
            l2_we_q      <= 1'b0;
            l2_addr_q    <= '0;
            l2_value_q   <= '0;
            vic_way_q    <= '0;
            fl_set_q     <= '0;
            fl_way_q     <= '0;
            for (int s = 0; s < S; s++)
                for (int w = 0; w < A; w++) meta_q[s][w] <= '0;
        end else begin
            if (flush_in && state_q != IDLE) flush_pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (flush_in || flush_pend_q) begin
                        flush_pend_q <= 1'b0;
                        fl_set_q     <= '0;
                        fl_way_q     <= '0;
                        state_q      <= FLUSH;
                    end else if (accept) begin
                        req_addr_q  <= lsu_addr_in;
                        req_value_q <= lsu_value_in;
                        req_tag_q   <= lsu_tag_in;
                        req_we_q    <= lsu_we_in;
                        if (hit) begin
                            resp_value_q <= lsu_we_in ? lsu_value_in : hit_line[in_word*64 +: 64];
                            if (lsu_we_in) meta_q[in_idx][hit_way].dirty <= 1'b1;
                            lsu_valid_q  <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            vic_way_q  <= vic_way;
                            l2_valid_q <= 1'b1;
                            if (meta_q[in_idx][vic_way].valid && meta_q[in_idx][vic_way].dirty) begin
                                l2_we_q    <= 1'b1;
                                l2_addr_q  <= {meta_q[in_idx][vic_way].tag[TAG_W-1:0], in_idx, {OFF_W{1'b0}}};
                                l2_value_q <= data_q[in_idx][vic_way];
                                state_q    <= WB;
                            end else begin
                                l2_we_q   <= 1'b0;
                                l2_addr_q <= {in_tag, in_idx, {OFF_W{1'b0}}};
                                state_q   <= FILL_REQ;
                            end
                        end
                    end
                end
                WB: begin
                    if (l2_ready_in) begin
                        l2_we_q   <= 1'b0;
                        l2_addr_q <= {rq_tag, rq_idx, {OFF_W{1'b0}}};
                        state_q   <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (l2_ready_in) begin
                        l2_valid_q <= 1'b0;
                        state_q    <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (l2_valid_in) begin
                        meta_q[rq_idx][vic_way_q].valid <= 1'b1;
                        meta_q[rq_idx][vic_way_q].dirty <= req_we_q;
                        meta_q[rq_idx][vic_way_q].tag   <= L1D_TAG_MAX'(rq_tag);
                        resp_value_q <= req_we_q ? req_value_q : l2_value_in[rq_word*64 +: 64];
                        lsu_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (lsu_ready_in) begin
                        lsu_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                FLUSH: begin
                    // A dirty line first raises a writeback; the line retires once it is accepted.
                    if (!l2_valid_q && fl_dirty) begin
                        l2_valid_q <= 1'b1;
                        l2_we_q    <= 1'b1;
                        l2_addr_q  <= {meta_q[fl_set_q][fl_way_q].tag[TAG_W-1:0], fl_set_q, {OFF_W{1'b0}}};
                        l2_value_q <= data_q[fl_set_q][fl_way_q];
                    end else if (!l2_valid_q || l2_ready_in) begin
                        l2_valid_q <= 1'b0;
                        l2_we_q    <= 1'b0;
                        meta_q[fl_set_q][fl_way_q] <= '0;
                        if (fl_last) begin
                            state_q <= IDLE;
                        end else if (fl_way_q == WAY_W'(A - 1)) begin
                            fl_way_q <= '0;
                            fl_set_q <= fl_set_q + 1'b1;
                        end else begin
                            fl_way_q <= fl_way_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lsu_valid_out          = lsu_valid_q;
    assign lsu_addr_out           = req_addr_q;
    assign lsu_value_out          = resp_value_q;
    assign lsu_tag_out            = req_tag_q;
    assign lsu_write_complete_out = lsu_valid_q & req_we_q;
    assign l2_valid_out           = l2_valid_q;
    assign l2_we_out              = l2_we_q;
    assign l2_addr_out            = l2_addr_q;
    assign l2_value_out           = l2_value_q;
    assign state_dbg_out          = state_q;

`ifdef L1D_STATS_EN
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            hit_count_out  <= '0;
            miss_count_out <= '0;
        end else if (state_q == IDLE && (flush_in || flush_pend_q)) begin
            hit_count_out  <= '0;
            miss_count_out <= '0;
        end else if (accept) begin
            if (hit) hit_count_out  <= hit_count_out + 32'd1;
            else     miss_count_out <= miss_count_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l1d_cache.sv
// Directed self-checking bench for l1d_cache: fills, store hits, eviction, flush, completion stall.
module tb_l1d_cache;
    import l1d_pkg::*;

    logic         clk_in = 1'b0;
    logic         rst_N_in = 1'b0;
    logic         cs_N_in = 1'b0;
    logic         flush_in = 1'b0;
    logic         lsu_valid_in = 1'b0;
    logic         lsu_ready_in = 1'b1;
    logic [63:0]  lsu_addr_in = '0;
    logic [63:0]  lsu_value_in = '0;
    logic [9:0]   lsu_tag_in = '0;
    logic         lsu_we_in = 1'b0;
    logic         lsu_valid_out, lsu_ready_out, lsu_write_complete_out;
    logic [63:0]  lsu_addr_out, lsu_value_out;
    logic [9:0]   lsu_tag_out;
    logic         l2_valid_out, l2_we_out;
    logic         l2_ready_in = 1'b0;
    logic [18:0]  l2_addr_out;
    logic [511:0] l2_value_out;
    logic         l2_valid_in = 1'b0;
    logic [511:0] l2_value_in = '0;
    l1d_state_e   state_dbg_out;
`ifdef L1D_STATS_EN
    logic [31:0]  hit_count_out, miss_count_out;
`endif

    int checks = 0;
    int errors = 0;
    int l2_hs_count = 0;

    l1d_cache dut (
        .clk_in                 (clk_in),
        .rst_N_in               (rst_N_in),
        .cs_N_in                (cs_N_in),
        .flush_in               (flush_in),
        .lsu_valid_in           (lsu_valid_in),
        .lsu_ready_in           (lsu_ready_in),
        .lsu_addr_in            (lsu_addr_in),
        .lsu_value_in           (lsu_value_in),
        .lsu_tag_in             (lsu_tag_in),
        .lsu_we_in              (lsu_we_in),
        .lsu_valid_out          (lsu_valid_out),
        .lsu_ready_out          (lsu_ready_out),
        .lsu_addr_out           (lsu_addr_out),
        .lsu_value_out          (lsu_value_out),
        .lsu_tag_out            (lsu_tag_out),
        .lsu_write_complete_out (lsu_write_complete_out),
        .l2_valid_out           (l2_valid_out),
        .l2_ready_in            (l2_ready_in),
        .l2_addr_out            (l2_addr_out),
        .l2_we_out              (l2_we_out),
        .l2_value_out           (l2_value_out),
        .l2_valid_in            (l2_valid_in),
        .l2_value_in            (l2_value_in),
        .state_dbg_out          (state_dbg_out)
`ifdef L1D_STATS_EN
        ,
        .hit_count_out          (hit_count_out),
        .miss_count_out         (miss_count_out)
`endif
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (l2_valid_out && l2_ready_in) l2_hs_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic issue(input logic [63:0] addr, input logic [63:0] val, input logic [9:0] tag,
                         input logic we, output bit ok);
        ok = 1'b0;
        @(negedge clk_in);
        lsu_addr_in  = addr;
        lsu_value_in = val;
        lsu_tag_in   = tag;
        lsu_we_in    = we;
        lsu_valid_in = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (lsu_ready_out) begin
                @(posedge clk_in);
                ok = 1'b1;
            end else begin
                @(negedge clk_in);
            end
        end
        #1 lsu_valid_in = 1'b0;
    endtask

    task automatic wait_l2(output logic [18:0] a, output logic we, output logic [511:0] v, output bit ok);
        ok = 1'b0;
        a  = '0;
        we = 1'b0;
        v  = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            if (l2_valid_out) begin
                a  = l2_addr_out;
                we = l2_we_out;
                v  = l2_value_out;
                l2_ready_in = 1'b1;
                @(posedge clk_in);
                #1 l2_ready_in = 1'b0;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic fill(input logic [63:0] base);
        @(negedge clk_in);
        for (int i = 0; i < 8; i++) l2_value_in[i*64 +: 64] = base + 64'(i);
        l2_valid_in = 1'b1;
        @(posedge clk_in);
        #1 l2_valid_in = 1'b0;
    endtask

    task automatic wait_resp(output logic [63:0] a, output logic [63:0] v, output logic [9:0] t,
                             output logic wc, output bit ok);
        ok = 1'b0;
        a  = '0;
        v  = '0;
        t  = '0;
        wc = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            if (lsu_valid_out) begin
                a  = lsu_addr_out;
                v  = lsu_value_out;
                t  = lsu_tag_out;
                wc = lsu_write_complete_out;
                ok = 1'b1;
                if (lsu_ready_in) begin
                    @(posedge clk_in);
                    #1;
                end
                break;
            end
        end
    endtask

    // tests
    task automatic test_reset();
        repeat (2) @(negedge clk_in);
        checks++;
        if (lsu_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", lsu_ready_out); end
        checks++;
        if (lsu_valid_out !== 1'b0) begin errors++; $display("FAIL reset_lsu_valid: got %b expected 0", lsu_valid_out); end
        checks++;
        if (l2_valid_out !== 1'b0) begin errors++; $display("FAIL reset_l2_valid: got %b expected 0", l2_valid_out); end
        checks++;
        if (lsu_value_out !== 64'h0 || lsu_tag_out !== 10'h0) begin
            errors++; $display("FAIL reset_outputs: value %h tag %h expected 0 0", lsu_value_out, lsu_tag_out);
        end
        cs_N_in = 1'b1;
        #1;
        checks++;
        if (lsu_ready_out !== 1'b0) begin errors++; $display("FAIL cs_deselect_ready: got %b expected 0", lsu_ready_out); end
        cs_N_in = 1'b0;
        @(negedge clk_in);
        rst_N_in = 1'b1;
    endtask

    task automatic test_cold_load();
        logic [18:0] a; logic we; logic [511:0] v; logic [63:0] ra, rv; logic [9:0] rt; logic wc; bit ok;
        issue(64'h1048, 64'h0, 10'd5, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL cold_accept: request not accepted"); end
        wait_l2(a, we, v, ok);
        checks++;
        if (!ok || a !== 19'h1040 || we !== 1'b0) begin
            errors++; $display("FAIL cold_l2_read: seen %0d addr %h we %b expected addr 01040 we 0", ok, a, we);
        end
        fill(64'h1000);
        wait_resp(ra, rv, rt, wc, ok);
        checks++;
        if (!ok || rv !== 64'h1001) begin errors++; $display("FAIL cold_value: got %h expected 1001", rv); end
        checks++;
        if (rt !== 10'd5 || wc !== 1'b0 || ra !== 64'h1048) begin
            errors++; $display("FAIL cold_echo: tag %0d wc %b addr %h expected 5 0 1048", rt, wc, ra);
        end
    endtask

    task automatic test_store_hit();
        logic [63:0] ra, rv; logic [9:0] rt; logic wc; bit ok; int base;
        base = l2_hs_count;
        issue(64'h1048, 64'hDEAD, 10'd6, 1'b1, ok);
        @(negedge clk_in);
        checks++;
        if (!ok || lsu_valid_out !== 1'b1) begin
            errors++; $display("FAIL hit_latency: valid %b one cycle after accept, expected 1", lsu_valid_out);
        end
        checks++;
        if (lsu_value_out !== 64'hDEAD || lsu_write_complete_out !== 1'b1 || lsu_tag_out !== 10'd6) begin
            errors++; $display("FAIL store_resp: value %h wc %b tag %0d expected dead 1 6",
                               lsu_value_out, lsu_write_complete_out, lsu_tag_out);
        end
        @(posedge clk_in);
        #1;
        issue(64'h1048, 64'h0, 10'd7, 1'b0, ok);
        wait_resp(ra, rv, rt, wc, ok);
        checks++;
        if (!ok || rv !== 64'hDEAD || wc !== 1'b0 || rt !== 10'd7) begin
            errors++; $display("FAIL load_after_store: value %h wc %b tag %0d expected dead 0 7", rv, wc, rt);
        end
        checks++;
        if (l2_hs_count !== base) begin
            errors++; $display("FAIL hit_no_l2: l2 handshakes %0d expected %0d", l2_hs_count, base);
        end
    endtask

    task automatic test_evict();
        logic [18:0] a; logic we; logic [511:0] v; logic [63:0] ra, rv; logic [9:0] rt; logic wc; bit ok;
        issue(64'h1240, 64'h0, 10'd8, 1'b0, ok);
        wait_l2(a, we, v, ok);
        checks++;
        if (!ok || a !== 19'h1240 || we !== 1'b0) begin errors++; $display("FAIL miss2_read: addr %h we %b expected 01240 0", a, we); end
        fill(64'h2000);
        wait_resp(ra, rv, rt, wc, ok);
        issue(64'h1440, 64'h0, 10'd9, 1'b0, ok);
        wait_l2(a, we, v, ok);
        checks++;
        if (!ok || a !== 19'h1440 || we !== 1'b0) begin errors++; $display("FAIL miss3_read: addr %h we %b expected 01440 0", a, we); end
        fill(64'h3000);
        wait_resp(ra, rv, rt, wc, ok);
        checks++;
        if (!ok || rv !== 64'h3000) begin errors++; $display("FAIL miss3_value: got %h expected 3000", rv); end
        issue(64'h1640, 64'h0, 10'd10, 1'b0, ok);
        wait_l2(a, we, v, ok);
        checks++;
        if (!ok || a !== 19'h1040 || we !== 1'b1) begin
            errors++; $display("FAIL evict_wb: addr %h we %b expected 01040 1", a, we);
        end
        checks++;
        if (v[127:64] !== 64'hDEAD || v[63:0] !== 64'h1000) begin
            errors++; $display("FAIL evict_wb_data: w1 %h w0 %h expected dead 1000", v[127:64], v[63:0]);
        end
        wait_l2(a, we, v, ok);
        checks++;
        if (!ok || a !== 19'h1640 || we !== 1'b0) begin errors++; $display("FAIL evict_read: addr %h we %b expected 01640 0", a, we); end
        fill(64'h4000);
        wait_resp(ra, rv, rt, wc, ok);
        checks++;
        if (!ok || rv !== 64'h4000 || rt !== 10'd10) begin errors++; $display("FAIL evict_value: got %h tag %0d expected 4000 10", rv, rt); end
    endtask

    task automatic test_flush();
        logic [18:0] a, wa; logic we, wwe; logic [511:0] v, wv;
        logic [63:0] ra, rv; logic [9:0] rt; logic wc; bit ok;
        int wb_n, cycles; bit done, saw_resp;
        issue(64'h1240, 64'h5555, 10'd11, 1'b1, ok);
        wait_resp(ra, rv, rt, wc, ok);
        @(negedge clk_in);
        flush_in     = 1'b1;
        lsu_valid_in = 1'b1;
        lsu_addr_in  = 64'h1048;
        lsu_we_in    = 1'b0;
        #1;
        checks++;
        if (lsu_ready_out !== 1'b0) begin errors++; $display("FAIL flush_priority_ready: got %b expected 0", lsu_ready_out); end
        @(posedge clk_in);
        #1;
        flush_in     = 1'b0;
        lsu_valid_in = 1'b0;
        wb_n = 0; done = 1'b0; saw_resp = 1'b0; cycles = 0;
        wa = '0; wwe = 1'b0; wv = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_in);
            if (lsu_valid_out) saw_resp = 1'b1;
            if (lsu_ready_out) begin done = 1'b1; cycles = i; break; end
            if (l2_valid_out) begin
                wb_n++;
                wa  = l2_addr_out;
                wwe = l2_we_out;
                wv  = l2_value_out;
                l2_ready_in = 1'b1;
                @(posedge clk_in);
                #1 l2_ready_in = 1'b0;
            end
        end
        checks++;
        if (!done || cycles < 24) begin errors++; $display("FAIL flush_walk: done %b cycles %0d expected done with >=24", done, cycles); end
        checks++;
        if (wb_n !== 1 || wa !== 19'h1240 || wwe !== 1'b1) begin
            errors++; $display("FAIL flush_wb: count %0d addr %h we %b expected 1 01240 1", wb_n, wa, wwe);
        end
        checks++;
        if (wv[63:0] !== 64'h5555 || wv[127:64] !== 64'h2001) begin
            errors++; $display("FAIL flush_wb_data: w0 %h w1 %h expected 5555 2001", wv[63:0], wv[127:64]);
        end
        checks++;
        if (saw_resp) begin errors++; $display("FAIL flush_blocked_req: completion seen %b expected 0", saw_resp); end
        issue(64'h1240, 64'h0, 10'd12, 1'b0, ok);
        wait_l2(a, we, v, ok);
        checks++;
        if (!ok || a !== 19'h1240 || we !== 1'b0) begin errors++; $display("FAIL post_flush_miss: addr %h we %b expected 01240 0", a, we); end
        fill(64'h6000);
        wait_resp(ra, rv, rt, wc, ok);
        checks++;
        if (!ok || rv !== 64'h6000) begin errors++; $display("FAIL post_flush_value: got %h expected 6000", rv); end
    endtask

    task automatic test_resp_stall();
        bit ok; int base;
        base = l2_hs_count;
        lsu_ready_in = 1'b0;
        issue(64'h1240, 64'h0, 10'h33, 1'b0, ok);
        lsu_valid_in = 1'b1;
        lsu_addr_in  = 64'h1048;
        lsu_tag_in   = 10'h44;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            checks++;
            if (lsu_valid_out !== 1'b1 || lsu_value_out !== 64'h6000 || lsu_tag_out !== 10'h33 || lsu_ready_out !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d]: valid %b value %h tag %h ready %b expected 1 6000 033 0",
                                   i, lsu_valid_out, lsu_value_out, lsu_tag_out, lsu_ready_out);
            end
        end
        lsu_ready_in = 1'b1;
        lsu_valid_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if (lsu_valid_out !== 1'b0 || lsu_ready_out !== 1'b1) begin
            errors++; $display("FAIL stall_release: valid %b ready %b expected 0 1", lsu_valid_out, lsu_ready_out);
        end
        checks++;
        if (l2_hs_count !== base) begin errors++; $display("FAIL stall_no_l2: handshakes %0d expected %0d", l2_hs_count, base); end
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_cold_load();
        test_store_hit();
        test_evict();
        test_flush();
        test_resp_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
